// File: rtl/fifo_burst_drain.sv
// Read-side drain for a registered-read FIFO: emits fixed-size bursts on a valid/ready stream,
// with partial bursts forced by flush or an idle timeout.
module fifo_burst_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
    input  logic                        fifo_empty,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                        flush,
    output logic                        m_valid,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(BURST_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [LW-1:0]         len;
    logic [LW-1:0]         issued;
    logic [LW-1:0]         sent;
    logic [TW-1:0]         timer;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ;

    logic fifo_nz;
    logic trig_full;
    logic trig_short;
    logic trigger;
    logic xfer;

    assign fifo_nz    = fifo_count != '0;
    assign trig_full  = fifo_count >= CW'(BURST_LEN);
    assign trig_short = fifo_nz && (flush || timer == TW'(TIMEOUT));
    assign trigger    = (state == IDLE) && (trig_full || trig_short);

    assign busy    = state == BURST;
    assign m_valid = occ != 2'd0;
    assign m_data  = buf_mem[rd_ptr];
    assign m_last  = m_valid && (sent == len - LW'(1));
    assign xfer    = m_valid && m_ready;

    // A read is only issued if the 3-entry buffer can absorb it even if the stream stalls.
    assign fifo_rd_en = busy && (issued < len) && !fifo_empty
                        && (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            issued   <= '0;
            sent     <= '0;
            timer    <= '0;
            inflight <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ      <= 2'd0;
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_rd_data;
                wr_ptr          <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (xfer) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
                sent   <= sent + LW'(1);
            end
            occ <= occ + {1'b0, inflight} - {1'b0, xfer};
            if (fifo_rd_en) issued <= issued + LW'(1);

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state  <= BURST;
                        len    <= trig_full ? LW'(BURST_LEN) : LW'(fifo_count);
                        issued <= '0;
                        sent   <= '0;
                        timer  <= '0;
                    end else if (!fifo_nz) begin
                        timer <= '0;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end
                end
                BURST: begin
                    timer <= '0;
                    if (xfer && m_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Read-side consumer of the synchronous show-ahead-free FIFO (SCFIFO_sync).
- Watches the FIFO occupancy and drains it in bursts of BURST_LEN beats onto a valid/ready stream, with a tlast-style marker on each burst's final beat.
- Emits a partial burst when data sits too long (idle timeout) or when the flush input is pulsed.
- Feeds the DMA/NAND-channel write path, which prefers fixed-size bursts.

Parameters:
- DATA_WIDTH, 64: FIFO word / stream data width.
- FIFO_DEPTH, 64: depth of the upstream FIFO; sets the fifo_count width.
- BURST_LEN, 16: full-burst beat count; 1 <= BURST_LEN <= FIFO_DEPTH.
- TIMEOUT, 255: idle cycles with a non-empty FIFO before a partial burst is forced; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty
- fifo_count  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- flush  in  1  single-cycle request to drain current contents immediately
- m_valid  out  1  stream beat valid
- m_data  out  DATA_WIDTH  stream beat data
- m_last  out  1  final beat of the burst
- m_ready  in  1  downstream accept
- busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset
  - Asynchronous: on rst rise, state=IDLE and all counters and the buffer are cleared.
  - Outputs during reset: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0.
  - Reset mid-burst discards in-flight beats; the FIFO's own reset is driven from the same rst.
- State IDLE
  - Idle timer counts +1 per cycle while fifo_count != 0. It clears when fifo_count == 0 or when a burst starts, and saturates at TIMEOUT.
  - Trigger checks, in priority order:
    - (a) fifo_count >= BURST_LEN: len = BURST_LEN.
    - (b) flush and fifo_count != 0: len = fifo_count.
    - (c) timer == TIMEOUT and fifo_count != 0: len = fifo_count.
  - On a trigger, latch len (width $clog2(BURST_LEN)+1) and go to BURST next cycle.
  - flush while the FIFO is empty is ignored. flush during BURST is dropped, not queued.
- State BURST
  - fifo_rd_en = (issued < len) && !fifo_empty && (occupancy + inflight <= 2).
    - occupancy: entries in the 3-entry output buffer.
    - inflight: 1 if fifo_rd_en was high the previous cycle.
    - fifo_rd_en does not depend on m_ready combinationally.
  - Data capture: fifo_rd_data is written into the output buffer on the cycle after each read strobe. The buffer can never overflow.
  - Stream output:
    - m_valid = occupancy != 0; m_data = head entry.
    - m_last = head entry is beat len-1 of the burst.
    - Beat transfer occurs when m_valid && m_ready.
  - Go to IDLE on the transfer of the m_last beat. A new trigger may be evaluated the next cycle.
- Latency and throughput
  - Trigger cycle T; first fifo_rd_en at T+1; first m_valid at T+3.
  - With m_ready held high, throughput is 1 beat/cycle after the first beat: a 16-beat burst spans T+3..T+18.
- Handshake rules
  - While m_valid && !m_ready: m_data and m_last hold stable and m_valid stays high.
  - Beats are delivered in FIFO order, with no drops or duplicates.
- Width and boundary rules
  - Counters: issued and sent are $clog2(BURST_LEN)+1 bits.
  - Burst sizing: len is sampled once at the trigger. Later FIFO writes do not extend the burst. This block is the FIFO's sole reader, so the sampled entries remain available.
  - Degenerate sizes: BURST_LEN=1 gives every beat m_last=1. A burst of len=1 asserts m_last on its only beat.
  - Full FIFO (fifo_count=FIFO_DEPTH) triggers rule (a) normally.

Test Plan:
1. Write 16 words 0..15, m_ready=1 → fifo_rd_en high 16 consecutive cycles; beats 0..15 on consecutive cycles; m_last only on data 15; busy falls after it.
2. Write 5 words (0xA0..0xA4), TIMEOUT=255 → no output for 255 cycles, then a 5-beat burst; m_last on 0xA4.
3. Write 3 words, pulse flush 10 cycles later → m_valid 3 cycles after the flush cycle; 3 beats; m_last on the 3rd. flush with the FIFO empty → nothing happens.
4. Write 16 words, m_ready toggling 1,0,1,0 → data held stable while stalled; 16 beats in order, none lost or duplicated; occupancy never exceeds 3.
5. Preload 40 words, m_ready=1 → bursts of 16 and 16, then an 8-beat burst after TIMEOUT; m_last on data 15, 31 and 39.
6. Assert rst after beat 7 of a 16-beat burst → m_valid, busy and fifo_rd_en go 0 immediately (asynchronously). After release, write 16 new words → a clean 16-beat burst starting from the new data.
